// File: rtl/uart_pkg.sv
// Shared types and address map for the memory-mapped UART.
// The address defaults are also mirrored in the top-level integration and software headers.
package uart_pkg;

  localparam int unsigned WORD_W = 17;
  localparam int unsigned BYTE_W = 8;

  localparam logic [WORD_W-1:0] UART_DATA_ADDR = 17'h1FFF0;
  localparam logic [WORD_W-1:0] UART_CTRL_ADDR = 17'h1FFF1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push while full is accepted when a pop
// happens in the same cycle. Written to be reused by a future RX path.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push against a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus UART transmitter: data-address stores queue bytes, an FSM sends them as 8N1.
// Control-address stores with bit 0 set clear the sticky overflow flag.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned        CLKS_PER_BIT = 434,
  parameter logic [WORD_W-1:0]  DATA_ADDR    = UART_DATA_ADDR,
  parameter logic [WORD_W-1:0]  CTRL_ADDR    = UART_CTRL_ADDR,
  parameter int unsigned        FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] DataAdr,
  input  logic [WORD_W-1:0] WriteData,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow
);

  localparam int unsigned     TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   LAST_CLK = TW'(CLKS_PER_BIT - 1);

  uart_state_t       state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic              data_sel;
  logic              ctrl_clr;
  logic              pop;
  logic              bit_done;
  logic [BYTE_W-1:0] rd_data;
  logic              unused_wdata;

  assign data_sel     = MemWrite && (DataAdr == DATA_ADDR);
  assign ctrl_clr     = MemWrite && (DataAdr == CTRL_ADDR) && WriteData[0];
  assign unused_wdata = ^WriteData[WORD_W-1:BYTE_W];

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (data_sel),
    .pop     (pop),
    .wr_data (WriteData[BYTE_W-1:0]),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_done = (timer_q == LAST_CLK);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = rd_data;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_d = '0;
          // Chain straight into the next start bit so queued bytes leave without a gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = rd_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    // Line level follows the state being entered, so tx stays a plain register.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    ovf_d = ovf_q;
    if (data_sel && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (ctrl_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule
